// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive sequencer.
//   rx_state_e            : receive FSM states (2-bit encoding)
//   *_DEFAULT             : default frame / oversampling parameters
//   SAMPLE_CNT_W          : width of the oversample counter
//   BIT_CNT_W             : width of the received-bit counter
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE_DEFAULT   = 16;
    localparam int DATA_BITS_DEFAULT    = 8;
    localparam int SAMPLE_POINT_DEFAULT = 7;

    // log2(OVERSAMPLE_DEFAULT); the counter runs 0..OVERSAMPLE-1
    localparam int SAMPLE_CNT_W = $clog2(OVERSAMPLE_DEFAULT);
    // Must hold 0..DATA_BITS inclusive for DATA_BITS up to 8
    localparam int BIT_CNT_W    = 4;

endpackage

// File: rtl/uart_rx_controller_if.sv
// ----------------------------------------------------------------------------
// uart_rx_controller_if
// Groups the tick/line inputs and character outputs of the receive sequencer.
//   sample_tick   : 16x baud enable (one clk wide)
//   serial_in     : raw RX line, idles high
//   sample_count  : current oversample count
//   bit_count     : data bits received in the current frame
//   busy          : receiver is inside a frame
//   char_data     : last good character
//   char_valid    : one-clk pulse when char_data updates
//   framing_error : one-clk pulse on a bad stop bit
// Modports: master = tick source / character consumer side,
//           slave  = the receive sequencer itself.
// ----------------------------------------------------------------------------
interface uart_rx_controller_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) ();

    logic                    sample_tick;
    logic                    serial_in;
    logic [SAMPLE_CNT_W-1:0] sample_count;
    logic [BIT_CNT_W-1:0]    bit_count;
    logic                    busy;
    logic [DATA_BITS-1:0]    char_data;
    logic                    char_valid;
    logic                    framing_error;

    modport master (
        output sample_tick,
        output serial_in,
        input  sample_count,
        input  bit_count,
        input  busy,
        input  char_data,
        input  char_valid,
        input  framing_error
    );

    modport slave (
        input  sample_tick,
        input  serial_in,
        output sample_count,
        output bit_count,
        output busy,
        output char_data,
        output char_valid,
        output framing_error
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous RX line. Both flops preset to 1
// on reset so the receiver sees an idle line and never a spurious start.
//   clk    : system clock
//   rst    : asynchronous active-high reset (presets flops to 1)
//   async_i: raw line
//   sync_o : synchronized line, two clk behind async_i
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx_controller.sv
// ----------------------------------------------------------------------------
// uart_rx_controller
// 16x-oversampled UART receive sequencer: detects and qualifies the start
// bit at mid-bit, shifts DATA_BITS data bits in LSB-first, checks the stop
// bit and reports either a good character or a framing error.
//   clk : system clock, all state changes on its rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of uart_rx_controller_if (tick/line in, char out)
// ----------------------------------------------------------------------------
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE   = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int SAMPLE_POINT = SAMPLE_POINT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_controller_if.slave  bus
);

    localparam logic [SAMPLE_CNT_W-1:0] SC_LAST = SAMPLE_CNT_W'(OVERSAMPLE - 1);
    localparam logic [SAMPLE_CNT_W-1:0] SC_MID  = SAMPLE_CNT_W'(SAMPLE_POINT);
    localparam logic [BIT_CNT_W-1:0]    BC_LAST = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_e               state_q,         state_d;
    logic [SAMPLE_CNT_W-1:0] sample_count_q,  sample_count_d;
    logic [BIT_CNT_W-1:0]    bit_count_q,     bit_count_d;
    logic [DATA_BITS-1:0]    shift_q,         shift_d;
    logic [DATA_BITS-1:0]    char_data_q,     char_data_d;
    logic                    char_valid_q,    char_valid_d;
    logic                    framing_error_q, framing_error_d;

    logic rx_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(bus.serial_in),
        .sync_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            sample_count_q  <= '0;
            bit_count_q     <= '0;
            shift_q         <= '0;
            char_data_q     <= '0;
            char_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sample_count_q  <= sample_count_d;
            bit_count_q     <= bit_count_d;
            shift_q         <= shift_d;
            char_data_q     <= char_data_d;
            char_valid_q    <= char_valid_d;
            framing_error_q <= framing_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        sample_count_d  = sample_count_q;
        bit_count_d     = bit_count_q;
        shift_d         = shift_q;
        char_data_d     = char_data_q;
        // Pulses fall back to 0 the cycle after they are raised
        char_valid_d    = 1'b0;
        framing_error_d = 1'b0;

        if (bus.sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d        = START;
                        sample_count_d = '0;
                        bit_count_d    = '0;
                    end
                end

                START: begin
                    if (sample_count_q != SC_MID) begin
                        sample_count_d = sample_count_q + SAMPLE_CNT_W'(1);
                    end else begin
                        // Mid-start-bit re-check; a high line here was a glitch
                        sample_count_d = '0;
                        state_d        = rx_s ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (sample_count_q != SC_LAST) begin
                        sample_count_d = sample_count_q + SAMPLE_CNT_W'(1);
                    end else begin
                        // LSB arrives first, so shift toward the LSB end
                        sample_count_d = '0;
                        shift_d        = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_count_d    = bit_count_q + BIT_CNT_W'(1);
                        if (bit_count_q == BC_LAST) begin
                            state_d = STOP;
                        end
                    end
                end

                STOP: begin
                    if (sample_count_q != SC_LAST) begin
                        sample_count_d = sample_count_q + SAMPLE_CNT_W'(1);
                    end else begin
                        // Leave at mid-stop-bit so an immediate next start is caught
                        sample_count_d = '0;
                        bit_count_d    = '0;
                        state_d        = IDLE;
                        if (rx_s) begin
                            char_data_d  = shift_q;
                            char_valid_d = 1'b1;
                        end else begin
                            framing_error_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.sample_count  = sample_count_q;
    assign bus.bit_count     = bit_count_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.char_data     = char_data_q;
    assign bus.char_valid    = char_valid_q;
    assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_controller
// Drives UART frames tick-by-tick and compares reported characters, their
// timing and the counters against expectations computed from frame arithmetic.
// ----------------------------------------------------------------------------
module tb_uart_rx_controller;
    import uart_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_controller_if bus_if ();

    uart_rx_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         tick;
    } ev_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         div      = 1;
    int         tick_no  = 0;
    int         frame_no = 0;
    logic [7:0] last_good = 8'h00;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t mon_ev;

    int   busy_rise_tick = -1;
    int   busy_fall_tick = -1;
    bit   rec_cnt = 1'b0;
    int   bc_tick_q[$];
    int   bc_val_q[$];
    int   wrap_q[$];
    logic       busy_prev = 1'b0;
    logic [3:0] sc_prev   = 4'd0;
    logic [3:0] bc_prev   = 4'd0;

    // Monitor: samples 1 time unit after each rising edge; tick edges are numbered
    always @(posedge clk) begin
        #1;
        if (bus_if.sample_tick) tick_no++;
        if (bus_if.char_valid || bus_if.framing_error) begin
            n_checks++;
            if (bus_if.char_valid && bus_if.framing_error)
                $display("FAIL pulse_exclusive: got char_valid=1 framing_error=1 required at most one high");
            else
                n_pass++;
            mon_ev.ferr = bus_if.framing_error;
            mon_ev.data = bus_if.char_data;
            mon_ev.tick = tick_no;
            obs_q.push_back(mon_ev);
        end
        if (bus_if.busy && !busy_prev) busy_rise_tick = tick_no;
        if (!bus_if.busy && busy_prev) busy_fall_tick = tick_no;
        if (rec_cnt) begin
            if (bus_if.bit_count != bc_prev) begin
                bc_tick_q.push_back(tick_no);
                bc_val_q.push_back(int'(bus_if.bit_count));
            end
            if (sc_prev == 4'd15 && bus_if.sample_count == 4'd0) wrap_q.push_back(tick_no);
        end
        busy_prev = bus_if.busy;
        sc_prev   = bus_if.sample_count;
        bc_prev   = bus_if.bit_count;
    end

    // Issue n ticks, one every div clocks; entered and left at a falling edge
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.sample_tick = 1'b1;
            @(negedge clk);
            bus_if.sample_tick = 1'b0;
            repeat (div - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus_if.serial_in = 1'b1;
        do_ticks(n);
    endtask

    // Line change lands before tick L; the 2-clk synchronizer makes the
    // receiver see it on tick L+2 when ticking every clk, else on tick L+1.
    function automatic int start_tick();
        return tick_no + 1 + ((div == 1) ? 2 : 1);
    endfunction

    task automatic send_frame(input logic [7:0] data, input bit stop, output int t0);
        ev_t e;
        t0 = start_tick();
        if (stop) last_good = data;
        e.ferr = !stop;
        e.data = last_good;
        e.tick = t0 + 8 + 16 * (8 + 1);
        exp_q.push_back(e);
        frame_no++;
        $display("frame %0d: data=%02h stop=%0b div=%0d start_tick=%0d", frame_no, data, stop, div, t0);
        bus_if.serial_in = 1'b0;
        do_ticks(16);
        for (int k = 0; k < 8; k++) begin
            bus_if.serial_in = data[k];
            do_ticks(16);
        end
        bus_if.serial_in = stop;
        do_ticks(16);
    endtask

    task automatic clear_events();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus_if.sample_tick = 1'b0;
        bus_if.serial_in   = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.sample_count !== 4'd0) $display("FAIL reset_sample_count: got %0d required 0", bus_if.sample_count); else n_pass++;
        n_checks++; if (bus_if.bit_count !== 4'd0) $display("FAIL reset_bit_count: got %0d required 0", bus_if.bit_count); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", bus_if.busy); else n_pass++;
        n_checks++; if (bus_if.char_data !== 8'h00) $display("FAIL reset_char_data: got %02h required 00", bus_if.char_data); else n_pass++;
        n_checks++; if (bus_if.char_valid !== 1'b0) $display("FAIL reset_char_valid: got %0b required 0", bus_if.char_valid); else n_pass++;
        n_checks++; if (bus_if.framing_error !== 1'b0) $display("FAIL reset_framing_error: got %0b required 0", bus_if.framing_error); else n_pass++;
        rst = 1'b0;
        idle(8);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL reset_idle_busy: got %0b required 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_good_frame();
        int t0;
        div = 1;
        idle(20);
        clear_events();
        send_frame(8'hA5, 1'b1, t0);
        idle(16);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL good_count: got %0d events required %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ferr !== exp_q[i].ferr || obs_q[i].data !== exp_q[i].data || obs_q[i].tick !== exp_q[i].tick)
                $display("FAIL good_event%0d: got ferr=%0b data=%02h tick=%0d required ferr=%0b data=%02h tick=%0d", i, obs_q[i].ferr, obs_q[i].data, obs_q[i].tick, exp_q[i].ferr, exp_q[i].data, exp_q[i].tick);
            else n_pass++;
        end
        n_checks++; if (bus_if.char_data !== 8'hA5) $display("FAIL good_char_data: got %02h required a5", bus_if.char_data); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL good_busy_after: got %0b required 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_false_start();
        int t0;
        div = 1;
        idle(20);
        clear_events();
        busy_rise_tick = -1;
        busy_fall_tick = -1;
        t0 = start_tick();
        $display("glitch: line low for 4 ticks, start_tick=%0d", t0);
        bus_if.serial_in = 1'b0;
        do_ticks(4);
        idle(30);
        n_checks++; if (obs_q.size() != 0) $display("FAIL false_start_events: got %0d events required 0", obs_q.size()); else n_pass++;
        n_checks++; if (busy_rise_tick != t0) $display("FAIL false_start_detect: got tick %0d required %0d", busy_rise_tick, t0); else n_pass++;
        n_checks++; if (busy_fall_tick != t0 + 8) $display("FAIL false_start_abort: got tick %0d required %0d", busy_fall_tick, t0 + 8); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL false_start_busy: got %0b required 0", bus_if.busy); else n_pass++;
        n_checks++; if (bus_if.char_data !== last_good) $display("FAIL false_start_hold: got %02h required %02h", bus_if.char_data, last_good); else n_pass++;
    endtask

    task automatic test_bad_stop();
        int t0;
        div = 4;
        idle(20);
        clear_events();
        send_frame(8'h3C, 1'b0, t0);
        idle(40);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL bad_stop_count: got %0d events required %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ferr !== exp_q[i].ferr || obs_q[i].data !== exp_q[i].data || obs_q[i].tick !== exp_q[i].tick)
                $display("FAIL bad_stop_event%0d: got ferr=%0b data=%02h tick=%0d required ferr=%0b data=%02h tick=%0d", i, obs_q[i].ferr, obs_q[i].data, obs_q[i].tick, exp_q[i].ferr, exp_q[i].data, exp_q[i].tick);
            else n_pass++;
        end
        n_checks++; if (bus_if.char_data !== 8'hA5) $display("FAIL bad_stop_hold: got %02h required a5", bus_if.char_data); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL bad_stop_busy: got %0b required 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        logic [7:0] partial;
        div = 1;
        idle(20);
        clear_events();
        partial = 8'($urandom);
        $display("partial frame: data=%02h aborted by reset after 3 bits", partial);
        bus_if.serial_in = 1'b0;
        do_ticks(16);
        for (int k = 0; k < 3; k++) begin
            bus_if.serial_in = partial[k];
            do_ticks(16);
        end
        bus_if.serial_in = partial[3];
        do_ticks(4);
        n_checks++; if (bus_if.bit_count !== 4'd3) $display("FAIL mid_bit_count: got %0d required 3", bus_if.bit_count); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL mid_busy: got %0b required 1", bus_if.busy); else n_pass++;
        #2;
        rst = 1'b1;
        bus_if.serial_in = 1'b1;
        #1;
        n_checks++; if (bus_if.sample_count !== 4'd0) $display("FAIL async_sample_count: got %0d required 0", bus_if.sample_count); else n_pass++;
        n_checks++; if (bus_if.bit_count !== 4'd0) $display("FAIL async_bit_count: got %0d required 0", bus_if.bit_count); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL async_busy: got %0b required 0", bus_if.busy); else n_pass++;
        n_checks++; if (bus_if.char_data !== 8'h00) $display("FAIL async_char_data: got %02h required 00", bus_if.char_data); else n_pass++;
        n_checks++; if (bus_if.char_valid !== 1'b0) $display("FAIL async_char_valid: got %0b required 0", bus_if.char_valid); else n_pass++;
        n_checks++; if (bus_if.framing_error !== 1'b0) $display("FAIL async_framing_error: got %0b required 0", bus_if.framing_error); else n_pass++;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        clear_events();
        idle(20);
        send_frame(8'h5A, 1'b1, t0);
        idle(16);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL after_reset_count: got %0d events required %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ferr !== exp_q[i].ferr || obs_q[i].data !== exp_q[i].data || obs_q[i].tick !== exp_q[i].tick)
                $display("FAIL after_reset_event%0d: got ferr=%0b data=%02h tick=%0d required ferr=%0b data=%02h tick=%0d", i, obs_q[i].ferr, obs_q[i].data, obs_q[i].tick, exp_q[i].ferr, exp_q[i].data, exp_q[i].tick);
            else n_pass++;
        end
        n_checks++; if (bus_if.char_data !== 8'h5A) $display("FAIL after_reset_char_data: got %02h required 5a", bus_if.char_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0a, t0b;
        div = 1;
        idle(20);
        clear_events();
        send_frame(8'h00, 1'b1, t0a);
        send_frame(8'hFF, 1'b1, t0b);
        idle(16);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d events required %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ferr !== exp_q[i].ferr || obs_q[i].data !== exp_q[i].data || obs_q[i].tick !== exp_q[i].tick)
                $display("FAIL b2b_event%0d: got ferr=%0b data=%02h tick=%0d required ferr=%0b data=%02h tick=%0d", i, obs_q[i].ferr, obs_q[i].data, obs_q[i].tick, exp_q[i].ferr, exp_q[i].data, exp_q[i].tick);
            else n_pass++;
        end
        if (obs_q.size() >= 2) begin
            n_checks++;
            if (obs_q[1].tick - obs_q[0].tick != 160)
                $display("FAIL b2b_spacing: got %0d ticks required 160", obs_q[1].tick - obs_q[0].tick);
            else n_pass++;
        end
    endtask

    task automatic test_counters();
        int t0;
        div = 1;
        idle(20);
        clear_events();
        bc_tick_q.delete();
        bc_val_q.delete();
        wrap_q.delete();
        busy_rise_tick = -1;
        rec_cnt = 1'b1;
        send_frame(8'h81, 1'b1, t0);
        idle(4);
        rec_cnt = 1'b0;
        n_checks++; if (busy_rise_tick != t0) $display("FAIL cnt_start_tick: got %0d required %0d", busy_rise_tick, t0); else n_pass++;
        n_checks++; if (bc_tick_q.size() != 9) $display("FAIL cnt_bit_steps: got %0d changes required 9", bc_tick_q.size()); else n_pass++;
        for (int k = 0; k < 9 && k < bc_tick_q.size(); k++) begin
            n_checks++;
            if (bc_val_q[k] != ((k < 8) ? k + 1 : 0) || bc_tick_q[k] != t0 + 8 + 16 * (k + 1))
                $display("FAIL cnt_bit_step%0d: got value=%0d tick=%0d required value=%0d tick=%0d", k, bc_val_q[k], bc_tick_q[k], (k < 8) ? k + 1 : 0, t0 + 8 + 16 * (k + 1));
            else n_pass++;
        end
        n_checks++; if (wrap_q.size() != 9) $display("FAIL cnt_wraps: got %0d wraps required 9", wrap_q.size()); else n_pass++;
        for (int k = 0; k < 9 && k < wrap_q.size(); k++) begin
            n_checks++;
            if (wrap_q[k] != t0 + 8 + 16 * (k + 1))
                $display("FAIL cnt_wrap%0d: got tick %0d required %0d", k, wrap_q[k], t0 + 8 + 16 * (k + 1));
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== 8'h81 || obs_q[0].tick != exp_q[0].tick)
            $display("FAIL cnt_char: got %0d events first data=%02h required 1 event data=81", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'h00);
        else n_pass++;
    endtask

    task automatic test_random();
        int t0;
        logic [7:0] d;
        bit stop;
        clear_events();
        for (int f = 0; f < 12; f++) begin
            div  = $urandom_range(1, 4);
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            idle($urandom_range(1, 20));
            send_frame(d, stop, t0);
            if (!stop) idle(40);
        end
        idle(20);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d events required %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ferr !== exp_q[i].ferr || obs_q[i].data !== exp_q[i].data || obs_q[i].tick !== exp_q[i].tick)
                $display("FAIL rand_event%0d: got ferr=%0b data=%02h tick=%0d required ferr=%0b data=%02h tick=%0d", i, obs_q[i].ferr, obs_q[i].data, obs_q[i].tick, exp_q[i].ferr, exp_q[i].data, exp_q[i].tick);
            else n_pass++;
        end
        n_checks++; if (bus_if.char_data !== last_good) $display("FAIL rand_char_data: got %02h required %02h", bus_if.char_data, last_good); else n_pass++;
    endtask

    initial begin
        bus_if.sample_tick = 1'b0;
        bus_if.serial_in   = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_false_start();
        test_bad_stop();
        test_reset_mid_frame();
        test_back_to_back();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Sequencer for the UART receive datapath, running at 16x oversampling.
- Detects the start bit, qualifies it at mid-bit, and drives the sample-count and bit-count sequencing.
- Shifts DATA_BITS data bits in LSB-first, checks the stop bit, and flags a completed character to the downstream char-detect logic.
- Sits between the baud-tick generator and the character consumer.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; power of 2; sets sample_count width (log2 = 4).
- DATA_BITS, 8, data bits per frame; range 5..8.
- SAMPLE_POINT, 7, sample_count value at which the start bit is re-checked.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-clk-wide 16x baud enable; counters advance only on ticks.
- serial_in  input  1  raw RX line; idles high; asynchronous to clk.
- sample_count  output  4  current oversample count (0..OVERSAMPLE-1).
- bit_count  output  4  data bits received in the current frame (0..DATA_BITS).
- busy  output  1  high in every state except IDLE.
- char_data  output  DATA_BITS  last good character; holds until the next good frame.
- char_valid  output  1  one-clk pulse when char_data updates.
- framing_error  output  1  one-clk pulse on a bad stop bit.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs, the shift register and the synchronizer flops go to 0, except synchronizer flops preset to 1 (idle line).
- Input synchronizer:
  - 2-flop synchronizer on serial_in; rx_s is the synchronized line.
  - rx_s lags serial_in by 2 clk. All line checks below use rx_s.
- No action on cycles where sample_tick=0; all counters and state hold.
- IDLE:
  - On a tick with rx_s=0: go to START, sample_count<=0, bit_count<=0.
- START, on each tick:
  - If sample_count != SAMPLE_POINT: sample_count++.
  - If sample_count == SAMPLE_POINT and rx_s=0: go to DATA, sample_count<=0.
  - If sample_count == SAMPLE_POINT and rx_s=1: false start, go to IDLE, sample_count<=0, no output pulses.
- DATA, on each tick:
  - If sample_count != OVERSAMPLE-1: sample_count++.
  - Else: shift rx_s into the MSB of the shift register (LSB-first frame), bit_count++, sample_count<=0.
  - When the bit just taken makes bit_count = DATA_BITS: go to STOP.
- STOP, on each tick:
  - If sample_count != OVERSAMPLE-1: sample_count++.
  - Else, sample the stop bit, then go to IDLE with sample_count<=0, bit_count<=0:
    - rx_s=1: char_data<=shift register, char_valid=1 for exactly one clk.
    - rx_s=0: framing_error=1 for exactly one clk; char_data unchanged; char_valid stays 0.
- Timing, with the start-detect tick as T0:
  - Start re-check at tick T0+8.
  - Data bit k (k=0..DATA_BITS-1) sampled at tick T0+8+16(k+1).
  - Stop bit sampled at T0+8+16(DATA_BITS+1), i.e. T0+152 for 8 bits.
  - Pulses are registered: high in the clk cycle after that tick's edge.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge on the next tick is detected normally.
- Line low continuously (break): each frame ends in framing_error. IDLE then immediately re-detects a start. No lockup.
- char_valid and framing_error are never both high.
- Reset mid-frame: immediate return to IDLE with outputs at 0. The partial character is discarded and never reported.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum {IDLE, START, DATA, STOP}, 2-bit encoding;
  - OVERSAMPLE_DEFAULT=16, DATA_BITS_DEFAULT=8, SAMPLE_POINT_DEFAULT=7;
  - the sample_count width constant.
- One sub-module: uart_rx_sync, the 2-flop synchronizer with async preset to 1.

Test Plan:
- Good frame: sample_tick every clk; send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1) -> one char_valid pulse, char_data=0xA5, framing_error=0, busy low afterwards.
- False start: line low for 4 ticks then high -> START aborted at T0+8; busy returns to 0; no char_valid, no framing_error; char_data holds its previous value.
- Bad stop bit: sample_tick every 4 clk; send 0x3C with stop=0 -> framing_error pulses once, char_valid=0, char_data keeps the prior 0xA5.
- Reset mid-frame: assert rst during DATA at bit_count=3 -> all outputs 0 asynchronously. Then send 0x5A -> char_data=0x5A, one char_valid.
- Back-to-back: 0x00 then 0xFF with a 1-bit stop and no idle gap -> two char_valid pulses 160 ticks apart, data 0x00 then 0xFF, no framing_error.
- Counter check: during 0x81 reception -> sample_count wraps 15->0 at every data sample; bit_count steps 0..8; sample instants match the T0+8+16(k+1) formula exactly.
